// File: rtl/motor_pwm_fsm_pkg.sv
// Shared types and default settings for the motor speed controller.
package motor_pkg;

  typedef enum logic [1:0] {
    S_STOP = 2'd0,
    S_LOW  = 2'd1,
    S_MID  = 2'd2,
    S_HIGH = 2'd3
  } speed_t;

  localparam int unsigned PWM_PERIOD_DEF   = 100;
  localparam int unsigned DUTY_LOW_DEF     = 25;
  localparam int unsigned DUTY_MID_DEF     = 50;
  localparam int unsigned DUTY_HIGH_DEF    = 75;
  localparam int unsigned DEBOUNCE_CYC_DEF = 20;

  // Speed-button ladder: STOP -> LOW -> MID -> HIGH -> STOP.
  function automatic speed_t speed_step(input speed_t cur);
    speed_t nxt;
    case (cur)
      S_STOP:  nxt = S_LOW;
      S_LOW:   nxt = S_MID;
      S_MID:   nxt = S_HIGH;
      default: nxt = S_STOP;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/motor_pwm_fsm_if.sv
// Button/timeout inputs and motor outputs of the speed controller.
// The master side drives the buttons and timeout; the slave is the controller.
interface motor_pwm_if;
  logic       i_btn_speed;
  logic       i_btn_stop;
  logic       i_timeout;
  logic       o_pwm;
  logic [1:0] o_speed;
  logic       o_running;

  modport master (
    output i_btn_speed, i_btn_stop, i_timeout,
    input  o_pwm, o_speed, o_running
  );

  modport slave (
    input  i_btn_speed, i_btn_stop, i_timeout,
    output o_pwm, o_speed, o_running
  );
endinterface

// File: rtl/motor_pwm_fsm_debounce.sv
// Raw push-button conditioner: two-flop synchroniser, stability counter,
// and a single-cycle pulse on each accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 20
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync_a;
  logic             sync_b;
  logic             level_d;
  logic [CNT_W-1:0] stable_cnt;

  // Bring the asynchronous button into the clock domain.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= i_btn;
      sync_b <= sync_a;
    end
  end

  // Accept a new level only after it has been seen on DEBOUNCE_CYC
  // consecutive samples; any bounce back to the old level restarts the count.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stable_cnt <= '0;
      o_level    <= 1'b0;
    end else if (sync_b == o_level) begin
      stable_cnt <= '0;
    end else if (stable_cnt == CNT_LAST) begin
      stable_cnt <= '0;
      o_level    <= sync_b;
    end else begin
      stable_cnt <= stable_cnt + 1'b1;
    end
  end

  // One-cycle pulse on the rising edge of the accepted level, so a held
  // button produces exactly one press.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      level_d <= 1'b0;
      o_press <= 1'b0;
    end else begin
      level_d <= o_level;
      o_press <= o_level & ~level_d;
    end
  end

endmodule

// File: rtl/motor_pwm_fsm.sv
// Motor speed controller: button-driven STOP/LOW/MID/HIGH state machine
// with a fixed-period PWM drive. A raised timer flag forces STOP and keeps
// the motor there until the flag drops.
//
//  state  | meaning
//  S_STOP | motor off, PWM duty 0
//  S_LOW  | PWM duty DUTY_LOW per period
//  S_MID  | PWM duty DUTY_MID per period
//  S_HIGH | PWM duty DUTY_HIGH per period
module motor_pwm_fsm
  import motor_pkg::*;
#(
  parameter int unsigned PWM_PERIOD   = PWM_PERIOD_DEF,
  parameter int unsigned DUTY_LOW     = DUTY_LOW_DEF,
  parameter int unsigned DUTY_MID     = DUTY_MID_DEF,
  parameter int unsigned DUTY_HIGH    = DUTY_HIGH_DEF,
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  motor_pwm_if.slave  bus
);

  localparam int unsigned CNT_W  = $clog2(PWM_PERIOD);
  localparam int unsigned DUTY_W = CNT_W + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PWM_PERIOD - 1);

  // Duties above the period clamp to the period, which keeps the output
  // permanently high since the counter never reaches PWM_PERIOD.
  localparam logic [DUTY_W-1:0] DUTY_LOW_SAT =
    (DUTY_LOW > PWM_PERIOD) ? DUTY_W'(PWM_PERIOD) : DUTY_W'(DUTY_LOW);
  localparam logic [DUTY_W-1:0] DUTY_MID_SAT =
    (DUTY_MID > PWM_PERIOD) ? DUTY_W'(PWM_PERIOD) : DUTY_W'(DUTY_MID);
  localparam logic [DUTY_W-1:0] DUTY_HIGH_SAT =
    (DUTY_HIGH > PWM_PERIOD) ? DUTY_W'(PWM_PERIOD) : DUTY_W'(DUTY_HIGH);

  speed_t            state;
  speed_t            state_nx;
  logic              press_speed;
  logic              press_stop;
  logic              level_speed;
  logic              level_stop;
  logic              unused_levels;
  logic              running_q;
  logic [CNT_W-1:0]  pwm_cnt;
  logic [DUTY_W-1:0] duty_tgt;
  logic [DUTY_W-1:0] duty_act;
  logic              pwm_q;

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_speed (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (bus.i_btn_speed),
    .o_level   (level_speed),
    .o_press   (press_speed)
  );

  button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_stop (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_btn     (bus.i_btn_stop),
    .o_level   (level_stop),
    .o_press   (press_stop)
  );

  // Only the press pulses steer the FSM; the held levels are not needed here.
  assign unused_levels = level_speed ^ level_stop;

  // Speed state and running flag registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= S_STOP;
      running_q <= 1'b0;
    end else begin
      state     <= state_nx;
      running_q <= (state_nx != S_STOP);
    end
  end

  // Next state: timeout beats a stop press, which beats a speed press.
  always_comb begin
    state_nx = state;
    if (bus.i_timeout) begin
      state_nx = S_STOP;
    end else if (press_stop) begin
      state_nx = S_STOP;
    end else if (press_speed) begin
      state_nx = speed_step(state);
    end
  end

  // Target duty for the current speed.
  always_comb begin
    duty_tgt = '0;
    case (state)
      S_LOW:   duty_tgt = DUTY_LOW_SAT;
      S_MID:   duty_tgt = DUTY_MID_SAT;
      S_HIGH:  duty_tgt = DUTY_HIGH_SAT;
      default: duty_tgt = '0;
    endcase
  end

  // Free-running period counter, active in every state.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_cnt <= '0;
    end else if (pwm_cnt == CNT_LAST) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
    end
  end

  // Active duty changes only at the period boundary to avoid runt pulses,
  // except that going to STOP kills the drive straight away.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      duty_act <= '0;
    end else if (state_nx == S_STOP) begin
      duty_act <= '0;
    end else if (pwm_cnt == CNT_LAST) begin
      duty_act <= duty_tgt;
    end
  end

  // Registered PWM compare.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= ({1'b0, pwm_cnt} < duty_act);
    end
  end

  assign bus.o_pwm     = pwm_q;
  assign bus.o_speed   = state;
  assign bus.o_running = running_q;

endmodule

// File: tb/tb_motor_pwm_fsm.sv
// Bench for motor_pwm_fsm: directed scenarios plus randomized button and
// timeout activity, checked against an event-level speed/duty model.
module tb_motor_pwm_fsm;

  localparam int PER = 10;
  localparam int DL  = 2;
  localparam int DM  = 5;
  localparam int DH  = 8;
  localparam int DB  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  motor_pwm_if bus();

  motor_pwm_fsm #(
    .PWM_PERIOD  (PER),
    .DUTY_LOW    (DL),
    .DUTY_MID    (DM),
    .DUTY_HIGH   (DH),
    .DEBOUNCE_CYC(DB)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int model_speed = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int duty_of(input int s);
    case (s)
      1:       return DL;
      2:       return DM;
      3:       return DH;
      default: return 0;
    endcase
  endfunction

  task automatic press(input bit spd, input bit stp, input int hold);
    bus.i_btn_speed = spd;
    bus.i_btn_stop  = stp;
    tick(hold);
    bus.i_btn_speed = 1'b0;
    bus.i_btn_stop  = 1'b0;
    tick(DB + 8);
  endtask

  // Speed, running flag, and number of high cycles over three periods.
  task automatic check_state(input string tag);
    int highs;
    chk({tag, "_speed"}, 32'(bus.o_speed), 32'(model_speed));
    chk({tag, "_running"}, 32'(bus.o_running), 32'(model_speed != 0));
    tick(3 * PER);
    highs = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick(1);
      highs += int'(bus.o_pwm);
    end
    chk({tag, "_duty"}, 32'(highs), 32'(3 * duty_of(model_speed)));
  endtask

  task automatic wait_pwm_rise(input string tag);
    int k;
    k = 0;
    while (bus.o_pwm !== 1'b0 && k < 4 * PER) begin
      tick(1);
      k++;
    end
    while (bus.o_pwm !== 1'b1 && k < 4 * PER) begin
      tick(1);
      k++;
    end
    chk({tag, "_pwm_rise"}, 32'(bus.o_pwm), 32'd1);
  endtask

  initial begin
    logic [39:0] smp;
    int run;
    int nruns;
    int highs;
    int op;
    int n;

    bus.i_btn_speed = 1'b0;
    bus.i_btn_stop  = 1'b0;
    bus.i_timeout   = 1'b0;

    // 1: reset and idle
    tick(3);
    chk("rst_pwm", 32'(bus.o_pwm), 32'd0);
    chk("rst_speed", 32'(bus.o_speed), 32'd0);
    chk("rst_running", 32'(bus.o_running), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk("idle_pwm", 32'(bus.o_pwm), 32'd0);
      chk("idle_speed", 32'(bus.o_speed), 32'd0);
      chk("idle_running", 32'(bus.o_running), 32'd0);
    end

    // 2: four clean speed presses walk the ladder and wrap
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, DB + 4);
      model_speed = (model_speed + 1) % 4;
      check_state("ladder");
    end

    // 3: short glitch is rejected, long hold gives one step
    bus.i_btn_speed = 1'b1;
    tick(2);
    bus.i_btn_speed = 1'b0;
    tick(DB + 8);
    check_state("glitch");
    press(1'b1, 1'b0, 100);
    model_speed = 1;
    check_state("hold");

    // 4: timeout from HIGH
    press(1'b1, 1'b0, DB + 4);
    press(1'b1, 1'b0, DB + 4);
    model_speed = 3;
    check_state("to_high");
    wait_pwm_rise("to");
    tick(2);
    bus.i_timeout = 1'b1;
    tick(1);
    chk("to_speed_next", 32'(bus.o_speed), 32'd0);
    chk("to_running_next", 32'(bus.o_running), 32'd0);
    tick(1);
    chk("to_pwm_after", 32'(bus.o_pwm), 32'd0);
    model_speed = 0;
    press(1'b1, 1'b0, DB + 6);
    press(1'b1, 1'b0, DB + 6);
    check_state("to_ignore");
    bus.i_timeout = 1'b0;
    tick(5);
    press(1'b1, 1'b0, DB + 4);
    model_speed = 1;
    check_state("to_release");

    // 5: LOW -> MID mid-period; press pulse lands on pwm_cnt=5
    wait_pwm_rise("mid");
    tick(7);
    bus.i_btn_speed = 1'b1;
    tick(DB + 3);
    chk("mid_before", 32'(bus.o_speed), 32'd1);
    tick(1);
    chk("mid_latency", 32'(bus.o_speed), 32'd2);
    bus.i_btn_speed = 1'b0;
    smp = '0;
    for (int i = 0; i < 40; i++) begin
      smp[i] = bus.o_pwm;
      tick(1);
    end
    run = 0;
    nruns = 0;
    for (int i = 0; i < 40; i++) begin
      if (smp[i]) begin
        run++;
      end else begin
        if (run > 0) begin
          chk("mid_run_len", 32'(run), 32'(DM));
          nruns++;
        end
        run = 0;
      end
    end
    chk("mid_runs", 32'(nruns >= 3), 32'd1);
    model_speed = 2;
    tick(DB + 8);
    check_state("mid_settled");

    // 6: simultaneous stop + speed from MID, then async reset mid-pulse
    press(1'b1, 1'b1, DB + 4);
    model_speed = 0;
    check_state("both");
    press(1'b1, 1'b0, DB + 4);
    model_speed = 1;
    check_state("pre_rst");
    wait_pwm_rise("rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_pwm", 32'(bus.o_pwm), 32'd0);
    chk("arst_speed", 32'(bus.o_speed), 32'd0);
    chk("arst_running", 32'(bus.o_running), 32'd0);
    tick(2);
    rst_n = 1'b1;
    model_speed = 0;
    check_state("post_rst");
    press(1'b1, 1'b0, DB + 4);
    model_speed = 1;
    check_state("post_rst_low");

    // Randomized activity
    for (int it = 0; it < 25; it++) begin
      op = int'($urandom_range(0, 4));
      case (op)
        0: begin
          press(1'b1, 1'b0, int'($urandom_range(DB + 2, 30)));
          model_speed = (model_speed + 1) % 4;
        end
        1: begin
          press(1'b0, 1'b1, int'($urandom_range(DB + 2, 30)));
          model_speed = 0;
        end
        2: begin
          press(1'b1, 1'b1, int'($urandom_range(DB + 2, 30)));
          model_speed = 0;
        end
        3: begin
          if ($urandom_range(0, 1) == 1) bus.i_btn_stop = 1'b1;
          else                            bus.i_btn_speed = 1'b1;
          tick(int'($urandom_range(1, DB - 1)));
          bus.i_btn_speed = 1'b0;
          bus.i_btn_stop  = 1'b0;
          tick(DB + 8);
        end
        default: begin
          bus.i_timeout = 1'b1;
          tick(2);
          model_speed = 0;
          n = int'($urandom_range(0, 2));
          for (int j = 0; j < n; j++) press(1'b1, 1'b0, int'($urandom_range(DB + 2, 20)));
          bus.i_timeout = 1'b0;
          tick(3);
        end
      endcase
      check_state("rnd");
    end

    // Timeout held: output must stay low over several periods
    bus.i_timeout = 1'b1;
    tick(2);
    highs = 0;
    for (int i = 0; i < 3 * PER; i++) begin
      tick(1);
      highs += int'(bus.o_pwm);
    end
    chk("to_hold_pwm", 32'(highs), 32'd0);
    bus.i_timeout = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
